// File: rtl/fim_resync_pkg.sv
// fim_resync_pkg: shared constants, chain-length clamp and synchronizer attribute strings
package fim_resync_pkg;

    localparam int SYNC_MIN_LEN = 2;

    localparam string PRESERVE_ATTR = "-name SYNCHRONIZER_IDENTIFICATION FORCED; -name PRESERVE_REGISTER ON";
    localparam string CUT_ATTR      = "-name CUT ON -from *";

    function automatic int clamp_len(input int n);
        return (n < SYNC_MIN_LEN) ? SYNC_MIN_LEN : n;
    endfunction

endpackage

// File: rtl/fim_resync_bit.sv
// fim_resync_bit: single-bit N-stage synchronizer chain with async active-low reset
module fim_resync_bit
    import fim_resync_pkg::*;
#(
    parameter int   N      = 3,
    parameter logic INIT   = 1'b0,
    parameter int   NO_CUT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int L = clamp_len(N);

    logic first;
    (* preserve, altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED; -name PRESERVE_REGISTER ON" *)
    logic [L-2:0] tail;

    // Only the capture stage may carry the false-path attribute
    if (NO_CUT == 0) begin : g_cut
        (* preserve, altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED; -name CUT ON -from *" *)
        logic s0;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) s0 <= INIT;
            else        s0 <= d;
        assign first = s0;
    end else begin : g_timed
        (* preserve, altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED" *)
        logic s0;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) s0 <= INIT;
            else        s0 <= d;
        assign first = s0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail <= {(L-1){INIT}};
        end else begin
            tail[0] <= first;
            for (int i = 1; i < L - 1; i++) tail[i] <= tail[i-1];
        end
    end

    assign q = tail[L-2];

endmodule

// File: rtl/fim_resync_chain.sv
// fim_resync_chain: per-bit multi-stage CDC synchronizer; FIM_RESYNC_CHANGE_DET_EN adds q_chg pulses
module fim_resync_chain
    import fim_resync_pkg::*;
#(
    parameter int SYNC_CHAIN_LENGTH = 3,
    parameter int WIDTH             = 1,
    parameter int INIT_VALUE        = 0,
    parameter int NO_CUT            = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef FIM_RESYNC_CHANGE_DET_EN
    ,
    output logic [WIDTH-1:0] q_chg
`endif
);

    localparam int   N    = clamp_len(SYNC_CHAIN_LENGTH);
    localparam logic INIT = INIT_VALUE[0];

    if (WIDTH < 1) begin : g_width_check
        $error("fim_resync_chain: WIDTH must be at least 1");
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        fim_resync_bit #(
            .N      (N),
            .INIT   (INIT),
            .NO_CUT (NO_CUT)
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (d[b]),
            .q     (q[b])
        );
    end

`ifdef FIM_RESYNC_CHANGE_DET_EN
    // q_d1 resets to INIT so reset release alone never produces a pulse
    logic [WIDTH-1:0] q_d1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q_d1 <= {WIDTH{INIT}};
        else        q_d1 <= q;
    assign q_chg = q ^ q_d1;
`endif

endmodule

// File: tb/tb_fim_resync_chain.sv
// tb_fim_resync_chain: randomized scoreboard bench against a history-queue model of the synchronizer
module tb_fim_resync_chain;

    typedef struct packed {
        logic [2:0] q;
        logic [2:0] q2;
        logic [2:0] chg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] d = 3'b111;
    logic [2:0] q, q2;
`ifdef FIM_RESYNC_CHANGE_DET_EN
    logic [2:0] q_chg, q2_chg;
`endif

    int checks = 0;
    int passes = 0;

    exp_t       exp_q[$];
    logic [2:0] hist[$];
    logic [2:0] prev_q = 3'b000;

    always #5 clk = ~clk;

    fim_resync_chain #(.SYNC_CHAIN_LENGTH(3), .WIDTH(3), .INIT_VALUE(0), .NO_CUT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .q     (q)
`ifdef FIM_RESYNC_CHANGE_DET_EN
        ,
        .q_chg (q_chg)
`endif
    );

    // Clamped chain (requested length 1), reset value 1, cut attribute variant
    fim_resync_chain #(.SYNC_CHAIN_LENGTH(1), .WIDTH(3), .INIT_VALUE(1), .NO_CUT(0)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .q     (q2)
`ifdef FIM_RESYNC_CHANGE_DET_EN
        ,
        .q_chg (q2_chg)
`endif
    );

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Value on q after an edge = the d captured (len-1) edges earlier, else reset value
    function automatic logic [2:0] model_q(input int len, input logic [2:0] init);
        return (hist.size() >= len) ? hist[hist.size() - len] : init;
    endfunction

    task automatic step(input logic [2:0] dv, input logic rv);
        exp_t e;
        @(negedge clk);
        d = dv;
        rst_n = rv;
        if (!rv) begin
            #1;
            chk("async_rst_q", q, 3'b000);
            chk("async_rst_q2", q2, 3'b111);
        end
        @(posedge clk);
        if (!rst_n) hist.delete();
        else hist.push_back(d);
        if (hist.size() > 4) void'(hist.pop_front());
        e.q   = model_q(3, 3'b000);
        e.q2  = model_q(2, 3'b111);
        e.chg = e.q ^ prev_q;
        prev_q = e.q;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("q", q, e.q);
                chk("q_clamped", q2, e.q2);
`ifdef FIM_RESYNC_CHANGE_DET_EN
                chk("q_chg", q_chg, e.chg);
`endif
            end
        end
    end

    initial begin : driver
        logic [2:0] dv;
        for (int i = 0; i < 5; i++) step(3'b111, 1'b0);
        for (int i = 0; i < 6; i++) step(3'b000, 1'b1);
        for (int i = 0; i < 6; i++) step(3'b101, 1'b1);
        step(3'b000, 1'b1);
        step(3'b111, 1'b1);
        step(3'b111, 1'b1);
        step(3'b111, 1'b0);
        step(3'b111, 1'b0);
        for (int i = 0; i < 5; i++) step(3'b111, 1'b1);
        dv = 3'b000;
        for (int i = 0; i < 20; i++) begin
            dv ^= (i % 2 == 0) ? 3'b001 : 3'b100;
            step(dv, 1'b1);
        end
        for (int i = 0; i < 4; i++) step(3'b000, 1'b1);
        for (int i = 0; i < 5; i++) step(3'b010, 1'b1);
        for (int i = 0; i < 300; i++) step(3'($urandom), ($urandom_range(0, 39) != 0));
        step(3'b000, 1'b1);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
